// File: rtl/updi_pkg.sv
// Shared UPDI definitions: instruction opcodes, pointer and size field codes,
// block-writer failure causes and block-writer FSM states.
package updi_pkg;

  typedef enum logic [3:0] {
    UPDI_LDS    = 4'h0,
    UPDI_STS    = 4'h1,
    UPDI_LD     = 4'h2,
    UPDI_ST     = 4'h3,
    UPDI_LDCS   = 4'h4,
    UPDI_STCS   = 4'h5,
    UPDI_REPEAT = 4'h6,
    UPDI_KEY    = 4'h7
  } updi_instruction;

  // Pointer-access field codes for LD/ST.
  localparam logic [1:0] PTR_INDIRECT = 2'd0;
  localparam logic [1:0] PTR_INC      = 2'd1;
  localparam logic [1:0] PTR_REG      = 2'd2;

  // Operand size field codes.
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_WORD = 2'd1;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'd0,
    ERR_LENGTH = 2'd1,
    ERR_ACK    = 2'd2
  } updi_err_code_e;

  typedef enum logic [3:0] {
    BW_IDLE,
    BW_SET_PTR,
    BW_SET_PTR_WAIT,
    BW_REPEAT,
    BW_REPEAT_WAIT,
    BW_STORE,
    BW_STORE_WAIT,
    BW_DONE,
    BW_ERROR
  } bw_state_e;

endpackage

// File: rtl/updi_block_writer.sv
// Writes a block of bytes into UPDI data space: one pointer load, then
// REPEAT + ST *ptr++ bursts of at most CHUNK_BYTES bytes until the block is done.
module updi_block_writer
  import updi_pkg::*;
#(
  parameter int MAX_DATA_SIZE  = 64,
  parameter int DATA_ADDR_BITS = $clog2(MAX_DATA_SIZE),
  parameter int CHUNK_BYTES    = MAX_DATA_SIZE / 2,
  parameter int BLOCK_MAX_SIZE = 128
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [15:0]               block_address,
  input  logic [7:0]                block_length,
  input  logic [7:0]                block_data [BLOCK_MAX_SIZE],
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic [1:0]                err_code,
  output logic                      instr_converter_en,
  output updi_instruction           instruction,
  output logic [1:0]                size_a,
  output logic [1:0]                size_b,
  output logic [1:0]                ptr,
  output logic [7:0]                data [MAX_DATA_SIZE],
  output logic [DATA_ADDR_BITS-1:0] data_len,
  output logic [MAX_DATA_SIZE-1:0]  wait_ack_after,
  output logic                      tx_start,
  input  logic                      tx_ready,
  input  logic                      ack_error
);

  localparam logic [7:0] CHUNK_N = 8'(CHUNK_BYTES);
  localparam int         BD_BITS = (BLOCK_MAX_SIZE > 1) ? $clog2(BLOCK_MAX_SIZE) : 1;

  bw_state_e      state_q, state_d;
  logic [15:0]    addr_q, addr_d;
  logic [7:0]     remaining_q, remaining_d;
  logic [7:0]     offset_q, offset_d;
  logic           armed_q, armed_d;
  logic           error_q, error_d;
  updi_err_code_e err_code_q, err_code_d;

  // Burst size from the registered count, and the size of the burst after it.
  logic [7:0] chunk_n;
  logic [7:0] rem_after;
  logic [7:0] chunk_after;

  assign chunk_n     = (remaining_q < CHUNK_N) ? remaining_q : CHUNK_N;
  assign rem_after   = remaining_q - chunk_n;
  assign chunk_after = (rem_after < CHUNK_N) ? rem_after : CHUNK_N;

  // Per-lane STORE payload: lane i carries block_data[offset+i] while i < n.
  logic [7:0]               store_byte [MAX_DATA_SIZE];
  logic [MAX_DATA_SIZE-1:0] store_mask;

  for (genvar gi = 0; gi < MAX_DATA_SIZE; gi++) begin : g_lane
    localparam logic [8:0] LANE = 9'(gi);
    logic [8:0] src_idx;
    assign src_idx         = {1'b0, offset_q} + LANE;
    assign store_mask[gi]  = (LANE < {1'b0, chunk_n});
    assign store_byte[gi]  = (store_mask[gi] && (src_idx < 9'(BLOCK_MAX_SIZE)))
                             ? block_data[src_idx[BD_BITS-1:0]] : 8'h00;
  end

  assign error    = error_q;
  assign err_code = err_code_q;

  // Next-state, counter updates and instruction fields for the current state.
  always_comb begin
    state_d            = state_q;
    addr_d             = addr_q;
    remaining_d        = remaining_q;
    offset_d           = offset_q;
    armed_d            = armed_q;
    error_d            = error_q;
    err_code_d         = err_code_q;
    busy               = (state_q != BW_IDLE);
    done               = 1'b0;
    instr_converter_en = 1'b0;
    instruction        = UPDI_ST;
    size_a             = SIZE_BYTE;
    size_b             = SIZE_BYTE;
    ptr                = PTR_INDIRECT;
    data               = '{default: 8'h00};
    data_len           = '0;
    wait_ack_after     = '0;
    tx_start           = 1'b0;

    unique case (state_q)
      BW_IDLE: begin
        if (start) begin
          addr_d      = block_address;
          error_d     = 1'b0;
          err_code_d  = ERR_NONE;
          remaining_d = '0;
          offset_d    = '0;
          if (block_length == 8'd0) begin
            state_d = BW_DONE;
          end else if ({1'b0, block_length} > 9'(BLOCK_MAX_SIZE)) begin
            state_d    = BW_ERROR;
            error_d    = 1'b1;
            err_code_d = ERR_LENGTH;
          end else begin
            state_d     = BW_SET_PTR;
            remaining_d = block_length;
          end
        end
      end

      BW_SET_PTR: begin
        instr_converter_en = 1'b1;
        ptr                = PTR_REG;
        size_b             = SIZE_WORD;
        data[0]            = addr_q[7:0];
        data[1]            = addr_q[15:8];
        data_len           = DATA_ADDR_BITS'(2);
        wait_ack_after[1]  = 1'b1;
        if (tx_ready) begin
          tx_start = 1'b1;
          armed_d  = 1'b0;
          state_d  = BW_SET_PTR_WAIT;
        end
      end

      BW_REPEAT: begin
        instr_converter_en = 1'b1;
        instruction        = UPDI_REPEAT;
        data[0]            = chunk_n - 8'd1;
        data_len           = DATA_ADDR_BITS'(1);
        if (tx_ready) begin
          tx_start = 1'b1;
          armed_d  = 1'b0;
          state_d  = BW_REPEAT_WAIT;
        end
      end

      BW_STORE: begin
        instr_converter_en = 1'b1;
        ptr                = PTR_INC;
        data               = store_byte;
        data_len           = DATA_ADDR_BITS'(chunk_n);
        wait_ack_after     = store_mask;
        if (tx_ready) begin
          tx_start = 1'b1;
          armed_d  = 1'b0;
          state_d  = BW_STORE_WAIT;
        end
      end

      BW_SET_PTR_WAIT, BW_REPEAT_WAIT, BW_STORE_WAIT: begin
        // The first wait cycle skips tx_ready, which may still show the pre-launch idle.
        if (ack_error) begin
          state_d    = BW_ERROR;
          error_d    = 1'b1;
          err_code_d = ERR_ACK;
        end else if (!armed_q) begin
          armed_d = 1'b1;
        end else if (tx_ready) begin
          if (state_q == BW_SET_PTR_WAIT) begin
            state_d = (chunk_n > 8'd1) ? BW_REPEAT : BW_STORE;
          end else if (state_q == BW_REPEAT_WAIT) begin
            state_d = BW_STORE;
          end else begin
            remaining_d = rem_after;
            offset_d    = offset_q + chunk_n;
            if (rem_after == 8'd0) begin
              state_d = BW_DONE;
            end else begin
              state_d = (chunk_after > 8'd1) ? BW_REPEAT : BW_STORE;
            end
          end
        end
      end

      BW_DONE: begin
        done    = 1'b1;
        state_d = BW_IDLE;
      end

      BW_ERROR: begin
        done    = 1'b1;
        state_d = BW_IDLE;
      end

      default: state_d = BW_IDLE;
    endcase
  end

  // State and datapath registers; rst returns to IDLE from any state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= BW_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      offset_q    <= '0;
      armed_q     <= 1'b0;
      error_q     <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      offset_q    <= offset_d;
      armed_q     <= armed_d;
      error_q     <= error_d;
      err_code_q  <= err_code_d;
    end
  end

endmodule

// File: tb/tb_updi_block_writer.sv
// Bench for updi_block_writer: a UPDI link responder captures every launched
// instruction; a chunking model built from block rules predicts the sequence.
module tb_updi_block_writer;
  import updi_pkg::*;

  localparam int MAXD  = 64;
  localparam int CHUNK = 32;
  localparam int BMAX  = 128;

  typedef struct packed {
    logic [3:0]       ins;
    logic [1:0]       ptr;
    logic [1:0]       sa;
    logic [1:0]       sb;
    logic             en;
    logic [7:0]       dlen;
    logic [63:0]      wack;
    logic [63:0][7:0] b;
  } txn_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [15:0]      block_address = '0;
  logic [7:0]       block_length = '0;
  logic [7:0]       bd [BMAX];
  logic             busy, done, error;
  logic [1:0]       err_code;
  logic             instr_converter_en;
  updi_instruction  instr_o;
  logic [1:0]       size_a, size_b, ptr;
  logic [7:0]       data_o [MAXD];
  logic [5:0]       data_len;
  logic [MAXD-1:0]  wait_ack_after;
  logic             tx_start;
  logic             tx_ready = 1'b1;
  logic             ack_error = 1'b0;

  int   tests = 0;
  int   fails = 0;
  int   done_cnt = 0;
  int   ready_lat = 3;
  int   hold_cnt = 0;
  bit   drop_next = 0;
  txn_t cap_q[$];
  txn_t exp_q[$];
  txn_t cap_t;

  updi_block_writer dut (
    .clk(clk), .rst(rst), .start(start),
    .block_address(block_address), .block_length(block_length), .block_data(bd),
    .busy(busy), .done(done), .error(error), .err_code(err_code),
    .instr_converter_en(instr_converter_en), .instruction(instr_o),
    .size_a(size_a), .size_b(size_b), .ptr(ptr),
    .data(data_o), .data_len(data_len), .wait_ack_after(wait_ack_after),
    .tx_start(tx_start), .tx_ready(tx_ready), .ack_error(ack_error)
  );

  always #5 clk = ~clk;

  // Link responder and monitor: capture launches, drop tx_ready for ready_lat cycles.
  always @(negedge clk) begin
    if (rst) begin
      tx_ready  = 1'b1;
      hold_cnt  = 0;
      drop_next = 0;
    end else begin
      if (drop_next) begin
        tx_ready  = 1'b0;
        hold_cnt  = ready_lat;
        drop_next = 0;
      end else if (hold_cnt > 0) begin
        hold_cnt--;
        if (hold_cnt == 0) tx_ready = 1'b1;
      end
      if (tx_start) begin
        cap_t      = '0;
        cap_t.ins  = instr_o;
        cap_t.ptr  = ptr;
        cap_t.sa   = size_a;
        cap_t.sb   = size_b;
        cap_t.en   = instr_converter_en;
        cap_t.dlen = {2'b00, data_len};
        cap_t.wack = wait_ack_after;
        for (int i = 0; i < MAXD; i++) cap_t.b[i] = data_o[i];
        cap_q.push_back(cap_t);
        drop_next = 1;
      end
    end
    if (done) done_cnt++;
  end

  // Expected instruction stream: pointer load, then bursts of min(remaining, CHUNK).
  task automatic build_expected(input logic [15:0] a, input int len);
    txn_t t;
    int rem, off, n;
    exp_q.delete();
    if (len == 0 || len > BMAX) return;
    t = '0; t.ins = UPDI_ST; t.ptr = 2'd2; t.sb = 2'd1; t.en = 1'b1; t.dlen = 8'd2;
    t.b[0] = a[7:0]; t.b[1] = a[15:8]; t.wack = 64'h2;
    exp_q.push_back(t);
    rem = len; off = 0;
    while (rem > 0) begin
      n = (rem < CHUNK) ? rem : CHUNK;
      if (n > 1) begin
        t = '0; t.ins = UPDI_REPEAT; t.en = 1'b1; t.dlen = 8'd1; t.b[0] = 8'(n - 1);
        exp_q.push_back(t);
      end
      t = '0; t.ins = UPDI_ST; t.ptr = 2'd1; t.en = 1'b1; t.dlen = 8'(n);
      for (int i = 0; i < n; i++) t.b[i] = bd[off + i];
      t.wack = (64'h1 << n) - 64'h1;
      exp_q.push_back(t);
      rem -= n;
      off += n;
    end
  endtask

  function automatic bit txn_equal(input txn_t a, input txn_t e);
    if (a.ins !== e.ins || a.ptr !== e.ptr || a.sa !== e.sa || a.sb !== e.sb ||
        a.en !== e.en || a.dlen !== e.dlen || a.wack !== e.wack) return 0;
    for (int i = 0; i < MAXD; i++)
      if (i < int'(e.dlen) && a.b[i] !== e.b[i]) return 0;
    return 1;
  endfunction

  function automatic string fmt_txn(input txn_t t);
    logic [7:0] last;
    last = (t.dlen == 0) ? 8'h00 : t.b[t.dlen - 8'd1];
    return $sformatf("ins=%0d ptr=%0d sa=%0d sb=%0d en=%0d len=%0d wack=%h b0=%h b1=%h blast=%h",
                     t.ins, t.ptr, t.sa, t.sb, t.en, t.dlen, t.wack, t.b[0], t.b[1], last);
  endfunction

  // One complete block: random payload, start pulse, bounded wait, sequence compare.
  task automatic run_block(input string name, input logic [15:0] a, input int len);
    int to;
    bit exp_err;
    logic [1:0] exp_code;
    for (int i = 0; i < BMAX; i++) bd[i] = 8'($urandom);
    build_expected(a, len);
    cap_q.delete();
    done_cnt = 0;
    @(negedge clk);
    block_address = a; block_length = 8'(len); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    to = 0;
    while (done_cnt == 0 && to < 4000) begin @(negedge clk); #1; to++; end
    repeat (4) @(negedge clk);
    #1;
    exp_err  = (len > BMAX);
    exp_code = (len > BMAX) ? 2'd1 : 2'd0;
    tests++;
    if (done_cnt != 1) begin fails++; $display("FAIL %s done_pulses: got %0d, expected 1", name, done_cnt); end
    tests++;
    if (cap_q.size() != exp_q.size()) begin
      fails++; $display("FAIL %s txn_count: got %0d, expected %0d", name, cap_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < cap_q.size(); k++) begin
      tests++;
      if (!txn_equal(cap_q[k], exp_q[k])) begin
        fails++;
        $display("FAIL %s txn %0d: got %s, expected %s", name, k, fmt_txn(cap_q[k]), fmt_txn(exp_q[k]));
      end else begin
        $display("[TB] %s txn %0d ok %s", name, k, fmt_txn(cap_q[k]));
      end
    end
    tests++;
    if (error !== exp_err) begin fails++; $display("FAIL %s error: got %b, expected %b", name, error, exp_err); end
    tests++;
    if (err_code !== exp_code) begin fails++; $display("FAIL %s err_code: got %0d, expected %0d", name, err_code, exp_code); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset busy: got %b, expected 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset done: got %b, expected 0", done); end
    tests++; if (error !== 1'b0) begin fails++; $display("FAIL reset error: got %b, expected 0", error); end
    tests++; if (err_code !== 2'd0) begin fails++; $display("FAIL reset err_code: got %0d, expected 0", err_code); end
    tests++; if (tx_start !== 1'b0) begin fails++; $display("FAIL reset tx_start: got %b, expected 0", tx_start); end
    tests++; if (instr_converter_en !== 1'b0) begin fails++; $display("FAIL reset instr_en: got %b, expected 0", instr_converter_en); end
    tests++; if (data_len !== 6'd0) begin fails++; $display("FAIL reset data_len: got %0d, expected 0", data_len); end
    tests++; if (wait_ack_after !== '0) begin fails++; $display("FAIL reset wait_ack_after: got %h, expected 0", wait_ack_after); end
  endtask

  task automatic test_basic();
    ready_lat = 3;
    run_block("basic", 16'h8000, 4);
  endtask

  task automatic test_long();
    ready_lat = 2;
    run_block("long70", 16'h1234, 70);
  endtask

  task automatic test_single();
    ready_lat = 1;
    run_block("single", 16'h4321, 1);
  endtask

  task automatic test_zero_len();
    cap_q.delete();
    done_cnt = 0;
    @(negedge clk);
    block_address = 16'h0100; block_length = 8'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL zero_len done_cycle1: got %b, expected 1", done); end
    @(negedge clk);
    #1;
    tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL zero_len idle_cycle2: got done=%b busy=%b, expected done=0 busy=0", done, busy);
    end
    tests++; if (cap_q.size() != 0) begin fails++; $display("FAIL zero_len tx_starts: got %0d, expected 0", cap_q.size()); end
    run_block("zero_len", 16'h0200, 0);
  endtask

  task automatic test_chunk_boundaries();
    ready_lat = 2;
    run_block("len32", 16'h2000, 32);
    run_block("len33", 16'h2100, 33);
    run_block("len128", 16'h2200, 128);
  endtask

  task automatic test_length_error();
    ready_lat = 2;
    run_block("len200", 16'h3000, 200);
    run_block("after_len_err", 16'h3100, 5);
  endtask

  task automatic test_start_ignored();
    cap_q.delete();
    done_cnt = 0;
    @(negedge clk);
    block_address = 16'h0000; block_length = 8'd0; start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    tests++; if (done_cnt != 1) begin fails++; $display("FAIL start_in_done done_pulses: got %0d, expected 1", done_cnt); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL start_in_done busy: got %b, expected 0", busy); end
  endtask

  task automatic test_ack_error();
    int to;
    ready_lat = 2;
    for (int i = 0; i < BMAX; i++) bd[i] = 8'($urandom);
    build_expected(16'hA5A0, 70);
    cap_q.delete();
    done_cnt = 0;
    @(negedge clk);
    block_address = 16'hA5A0; block_length = 8'd70; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    to = 0;
    while (cap_q.size() < 1 && to < 500) begin @(negedge clk); #1; to++; end
    @(negedge clk);
    block_address = 16'hBEEF; block_length = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    to = 0;
    while (cap_q.size() < 5 && to < 2000) begin @(negedge clk); #1; to++; end
    tests++;
    if (cap_q.size() < 5) begin fails++; $display("FAIL ack_err reach_store2: got %0d txns, expected 5", cap_q.size()); end
    @(negedge clk);
    ack_error = 1'b1;
    @(negedge clk);
    ack_error = 1'b0;
    to = 0;
    while (done_cnt == 0 && to < 500) begin @(negedge clk); #1; to++; end
    repeat (8) @(negedge clk);
    #1;
    tests++;
    if (cap_q.size() != 5) begin fails++; $display("FAIL ack_err txn_count: got %0d, expected 5", cap_q.size()); end
    for (int k = 0; k < 5 && k < cap_q.size(); k++) begin
      tests++;
      if (!txn_equal(cap_q[k], exp_q[k])) begin
        fails++;
        $display("FAIL ack_err txn %0d: got %s, expected %s", k, fmt_txn(cap_q[k]), fmt_txn(exp_q[k]));
      end else begin
        $display("[TB] ack_err txn %0d ok %s", k, fmt_txn(cap_q[k]));
      end
    end
    tests++; if (done_cnt != 1) begin fails++; $display("FAIL ack_err done_pulses: got %0d, expected 1", done_cnt); end
    tests++; if (error !== 1'b1) begin fails++; $display("FAIL ack_err error: got %b, expected 1", error); end
    tests++; if (err_code !== 2'd2) begin fails++; $display("FAIL ack_err err_code: got %0d, expected 2", err_code); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL ack_err busy: got %b, expected 0", busy); end
  endtask

  task automatic test_reset_mid();
    int to;
    ready_lat = 3;
    cap_q.delete();
    @(negedge clk);
    block_address = 16'h5555; block_length = 8'd40; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    to = 0;
    while (cap_q.size() < 2 && to < 500) begin @(negedge clk); #1; to++; end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_mid busy: got %b, expected 0", busy); end
    tests++; if (tx_start !== 1'b0) begin fails++; $display("FAIL rst_mid tx_start: got %b, expected 0", tx_start); end
    tests++; if (cap_q.size() != 2) begin fails++; $display("FAIL rst_mid txn_count: got %0d, expected 2", cap_q.size()); end
    rst = 1'b0;
    run_block("after_rst", 16'h6666, 20);
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      ready_lat = int'($urandom_range(1, 5));
      run_block($sformatf("rand%0d", r), 16'($urandom), int'($urandom_range(1, BMAX)));
    end
  endtask

  initial begin
    for (int i = 0; i < BMAX; i++) bd[i] = 8'h00;
    test_reset();
    test_basic();
    test_long();
    test_single();
    test_zero_len();
    test_chunk_boundaries();
    test_length_error();
    test_start_ignored();
    test_ack_error();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
